fifo_wr_arbiter: RTL

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

---
 rtl/fifo_wr_arbiter_pkg.sv | 20 ++
 rtl/fifo_wr_arbiter_rr_pick.sv | 37 +++
 rtl/fifo_wr_arbiter.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/fifo_wr_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// fifo_wr_arbiter_pkg
// Shared definitions for the shared-FIFO write arbiter:
//   - state_t         : arbiter FSM state (IDLE, BURST)
//   - DEF_N_REQ       : default number of write requesters
//   - DEF_WIDTH       : default data width (matches the shared FIFO width)
//   - DEF_MAX_BURST   : default beats per grant before a forced release
// ---------------------------------------------------------------------------
package fifo_wr_arbiter_pkg;

    localparam int DEF_N_REQ     = 4;
    localparam int DEF_WIDTH     = 4;
    localparam int DEF_MAX_BURST = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Purely combinational round-robin picker. The search starts at index ptr
// and wraps at N-1, so the requester at ptr has the highest priority.
// Ports:
//   req : N   requests
//   ptr : PW  index where the search starts
//   gnt : N   one-hot winner, all-zero when there is no request
//   any : 1   at least one request is present
// ---------------------------------------------------------------------------
module rr_pick #(
    parameter int N  = 4,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic          any
);

    int w_idx;

    always_comb begin
        gnt   = '0;
        any   = 1'b0;
        w_idx = 0;
        for (int k = 0; k < N; k++) begin
            w_idx = (int'(ptr) + k) % N;
            // First hit in rotated order wins; later hits are ignored.
            if (!any && req[w_idx]) begin
                gnt[w_idx] = 1'b1;
                any        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_wr_arbiter
// Arbitrates N_REQ packet writers onto one shared FIFO write port. A grant is
// taken in IDLE (round-robin from rr_ptr) and held for a whole burst, which
// ends on an accepted last beat or after MAX_BURST accepted beats.
// Handshake: a beat transfers on a cycle where req_valid[i] & req_ready[i]
// are both high at the rising clock edge; req_ready only rises for the
// current owner while the FIFO is not full, and fifo_wr_en mirrors exactly
// that transfer.
// Ports:
//   clk, rst_n         : clock, asynchronous active-low reset
//   req_valid/last     : N_REQ per-requester beat valid / last-of-packet
//   req_data           : N_REQ*WIDTH, requester i at [i*WIDTH +: WIDTH]
//   req_ready          : N_REQ per-requester beat accepted
//   fifo_wdata/wr_en   : write port to the shared FIFO
//   fifo_full          : shared FIFO full flag
//   grant              : one-hot owner, zero when idle
//   busy               : high while a grant is held
//   dbg_state/rr_ptr/beat_cnt : FSM state and internal counters for observation
// ---------------------------------------------------------------------------
module fifo_wr_arbiter
    import fifo_wr_arbiter_pkg::*;
#(
    parameter int N_REQ     = DEF_N_REQ,
    parameter int WIDTH     = DEF_WIDTH,
    parameter int MAX_BURST = DEF_MAX_BURST,
    parameter int PW        = $clog2(N_REQ),
    parameter int CW        = $clog2(MAX_BURST) + 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*WIDTH-1:0] req_data,
    input  logic [N_REQ-1:0]       req_last,
    output logic [N_REQ-1:0]       req_ready,
    output logic [WIDTH-1:0]       fifo_wdata,
    output logic                   fifo_wr_en,
    input  logic                   fifo_full,
    output logic [N_REQ-1:0]       grant,
    output logic                   busy,
    output state_t                 dbg_state,
    output logic [PW-1:0]          dbg_rr_ptr,
    output logic [CW-1:0]          dbg_beat_cnt
);

    state_t            r_state,    w_state_nxt;
    logic [N_REQ-1:0]  r_grant,    w_grant_nxt;
    logic [PW-1:0]     r_rr_ptr,   w_rr_ptr_nxt;
    logic [CW-1:0]     r_beat_cnt, w_beat_cnt_nxt;

    logic [N_REQ-1:0]  w_pick_gnt;
    logic              w_pick_any;
    logic [PW-1:0]     w_owner_idx;
    logic [WIDTH-1:0]  w_wdata;
    logic              w_busy;
    logic              w_accept;
    logic              w_owner_last;
    logic [CW-1:0]     w_cnt_inc;

    rr_pick #(
        .N  (N_REQ),
        .PW (PW)
    ) u_rr_pick (
        .req (req_valid),
        .ptr (r_rr_ptr),
        .gnt (w_pick_gnt),
        .any (w_pick_any)
    );

    // Owner index and one-hot AND-OR data mux; r_grant is zero in IDLE.
    always_comb begin
        w_owner_idx = '0;
        w_wdata     = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (r_grant[i]) begin
                w_owner_idx = PW'(i);
            end
            w_wdata = w_wdata | (req_data[i*WIDTH +: WIDTH] & {WIDTH{r_grant[i]}});
        end
    end

    assign w_busy       = (r_state == BURST);
    assign w_owner_last = |(req_last & r_grant);
    assign w_accept     = w_busy && |(req_valid & r_grant) && !fifo_full;
    assign w_cnt_inc    = r_beat_cnt + CW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_grant    <= '0;
            r_rr_ptr   <= '0;
            r_beat_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_grant    <= w_grant_nxt;
            r_rr_ptr   <= w_rr_ptr_nxt;
            r_beat_cnt <= w_beat_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_grant_nxt    = r_grant;
        w_rr_ptr_nxt   = r_rr_ptr;
        w_beat_cnt_nxt = r_beat_cnt;
        case (r_state)
            IDLE: begin
                if (w_pick_any) begin
                    w_state_nxt = BURST;
                    w_grant_nxt = w_pick_gnt;
                end
            end
            BURST: begin
                if (w_accept) begin
                    // Release on last beat or when the beat budget is used up;
                    // an unfinished packet simply continues on its next grant.
                    if (w_owner_last || (w_cnt_inc == CW'(MAX_BURST))) begin
                        w_state_nxt    = IDLE;
                        w_grant_nxt    = '0;
                        w_beat_cnt_nxt = '0;
                        w_rr_ptr_nxt   = (w_owner_idx == PW'(N_REQ - 1)) ? '0
                                                                         : w_owner_idx + PW'(1);
                    end else begin
                        w_beat_cnt_nxt = w_cnt_inc;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_grant_nxt = '0;
            end
        endcase
    end

    assign req_ready    = (w_busy && !fifo_full) ? r_grant : '0;
    assign fifo_wr_en   = w_accept;
    assign fifo_wdata   = w_wdata;
    assign grant        = r_grant;
    assign busy         = w_busy;
    assign dbg_state    = r_state;
    assign dbg_rr_ptr   = r_rr_ptr;
    assign dbg_beat_cnt = r_beat_cnt;

endmodule
